// File: rtl/ysyx_22040127_ifu.sv
// Instruction fetch unit: fetches 64-bit doublewords, keeps a one-line buffer,
// and hands instruction/PC pairs to decode over a valid/ready handshake.
module ysyx_22040127_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          XLEN_MEM = 64
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [31:0]         mem_req_addr,
    input  logic                mem_resp_valid,
    input  logic [XLEN_MEM-1:0] mem_resp_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         inst,
    output logic [31:0]         inst_pc,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    input  logic                fence_i
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    logic [1:0]          state;
    logic [31:0]         pc;
    logic                buf_valid;
    logic [31:3]         buf_tag;
    logic [XLEN_MEM-1:0] buf_data;
    logic                discard;
    logic                hit;
    logic [31:0]         buf_word;
    logic [31:0]         resp_word;

    assign hit       = buf_valid && (buf_tag == pc[31:3]);
    assign buf_word  = pc[2] ? buf_data[63:32] : buf_data[31:0];
    assign resp_word = pc[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];

    // A redirect in the same cycle must never launch a request for the stale pc.
    assign mem_req_valid = !rst && (state == S_FETCH) && !hit && !redirect_valid;
    assign mem_req_addr  = {pc[31:3], 3'b000};
    assign inst_valid    = !rst && (state == S_OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            discard   <= 1'b0;
            inst      <= 32'd0;
            inst_pc   <= 32'd0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_pc & 32'hFFFF_FFFC;
                case (state)
                    S_WAIT: begin
                        // An in-flight response still has to be absorbed before refetching.
                        if (mem_resp_valid) begin
                            state   <= S_FETCH;
                            discard <= 1'b0;
                        end else begin
                            discard <= 1'b1;
                        end
                    end
                    default: state <= S_FETCH;
                endcase
            end else begin
                case (state)
                    S_FETCH: begin
                        if (hit) begin
                            inst    <= buf_word;
                            inst_pc <= pc;
                            state   <= S_OUT;
                        end else if (mem_req_ready) begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (mem_resp_valid) begin
                            if (discard) begin
                                discard <= 1'b0;
                                state   <= S_FETCH;
                            end else begin
                                buf_valid <= 1'b1;
                                buf_tag   <= pc[31:3];
                                buf_data  <= mem_resp_data;
                                inst      <= resp_word;
                                inst_pc   <= pc;
                                state     <= S_OUT;
                            end
                        end
                    end
                    S_OUT: begin
                        if (inst_ready) begin
                            pc    <= pc + 32'd4;
                            state <= S_FETCH;
                        end
                    end
                    default: state <= S_FETCH;
                endcase
            end
            // Placed last so fence.i wins over a fill in the same cycle.
            if (fence_i) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040127_ifu.sv
// Self-checking bench for ysyx_22040127_ifu: directed scenarios plus a
// randomized run checked against a program-order PC model.
module tb_ysyx_22040127_ifu;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fence_i;

    int errors;
    int checks;
    int cycle;
    int req_count;

    // memory model state
    int          ready_delay;
    int          resp_lat;
    int          req_wait;
    bit          hold_ready;
    bit          stray_resp;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;

    // values observed in the most recent cycle, sampled before its clock edge
    bit          obs_req_valid;
    bit          obs_req_fire;
    logic [31:0] obs_req_addr;
    bit          obs_resp;
    bit          obs_inst_valid;
    logic [31:0] obs_inst;
    logic [31:0] obs_inst_pc;
    bit          obs_accept;
    bit          obs_rst;

    ysyx_22040127_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fence_i        (fence_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0013;
        if (a == 32'h8000_0004) return 32'h0010_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] dword_at(input logic [31:0] a);
        return {word_at({a[31:3], 3'b100}), word_at({a[31:3], 3'b000})};
    endfunction

    // One clock cycle: memory reacts to the settled request, outputs are
    // sampled, the edge happens, then the memory model advances.
    task automatic tick();
        #1;
        mem_req_ready  = mem_req_valid && !hold_ready && (req_wait >= ready_delay);
        mem_resp_valid = (pend && pend_cnt == 0) || stray_resp;
        mem_resp_data  = (pend && pend_cnt == 0) ? dword_at(pend_addr) : 64'hDEAD_BEEF_CAFE_F00D;
        #1;
        obs_rst        = rst;
        obs_req_valid  = mem_req_valid;
        obs_req_addr   = mem_req_addr;
        obs_req_fire   = mem_req_valid && mem_req_ready;
        obs_resp       = mem_resp_valid;
        obs_inst_valid = inst_valid;
        obs_inst       = inst;
        obs_inst_pc    = inst_pc;
        obs_accept     = inst_valid && inst_ready && !redirect_valid && !rst;
        if (obs_req_fire) req_count++;
        @(posedge clk);
        #1;
        if (obs_rst) begin
            pend     = 1'b0;
            req_wait = 0;
        end else begin
            if (pend && pend_cnt == 0) pend = 1'b0;
            else if (pend) pend_cnt--;
            if (obs_req_fire) begin
                pend      = 1'b1;
                pend_addr = obs_req_addr;
                pend_cnt  = resp_lat - 1;
                req_wait  = 0;
            end else if (obs_req_valid) begin
                req_wait++;
            end else begin
                req_wait = 0;
            end
        end
        cycle++;
    endtask

    task automatic wait_fire(input string name);
        int n = 0;
        do begin tick(); n++; end while (!obs_req_fire && n < 30);
        checks++;
        if (!obs_req_fire) begin
            errors++;
            $display("[TB] FAIL %s: no request accepted within %0d cycles, got 0 required 1", name, n);
        end
    endtask

    task automatic wait_inst(input string name);
        int n = 0;
        do begin tick(); n++; end while (!obs_inst_valid && n < 30);
        checks++;
        if (!obs_inst_valid) begin
            errors++;
            $display("[TB] FAIL %s: no inst_valid within %0d cycles, got 0 required 1", name, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; fence_i = 1'b0;
        hold_ready = 1'b0; stray_resp = 1'b0; pend = 1'b0; req_wait = 0;
        ready_delay = 1; resp_lat = 2;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 64'd0;
        tick();
        tick();
        checks++;
        if (obs_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_req: mem_req_valid got %b required 0", obs_req_valid);
        end
        checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL reset_out: got valid=%b inst=%h pc=%h required 0/0/0", inst_valid, inst, inst_pc);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        int n = 0;
        wait_fire("first_req");
        checks++;
        if (obs_req_addr !== 32'h8000_0000) begin
            errors++;
            $display("[TB] FAIL first_addr: got %h required 80000000", obs_req_addr);
        end
        do begin tick(); n++; end while (!obs_resp && n < 30);
        tick();
        checks++;
        if ({obs_inst_valid, obs_inst, obs_inst_pc} !== {1'b1, 32'h0000_0013, 32'h8000_0000}) begin
            errors++;
            $display("[TB] FAIL first_inst: got valid=%b inst=%h pc=%h required 1/00000013/80000000",
                     obs_inst_valid, obs_inst, obs_inst_pc);
        end
    endtask

    task automatic test_decode_stall();
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({obs_inst_valid, obs_inst, obs_inst_pc, obs_req_valid} !== {1'b1, 32'h0000_0013, 32'h8000_0000, 1'b0}) begin
                errors++;
                $display("[TB] FAIL stall_%0d: got valid=%b inst=%h pc=%h req=%b required 1/00000013/80000000/0",
                         i, obs_inst_valid, obs_inst, obs_inst_pc, obs_req_valid);
            end
        end
    endtask

    task automatic test_buffer_hit();
        int rq;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++;
        if (obs_accept !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hit_handshake: got %b required 1", obs_accept);
        end
        rq = req_count;
        tick();
        checks++;
        if ({obs_inst_valid, obs_req_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL hit_fetch_cycle: got valid=%b req=%b required 0/0", obs_inst_valid, obs_req_valid);
        end
        tick();
        checks++;
        if ({obs_inst_valid, obs_inst, obs_inst_pc} !== {1'b1, 32'h0010_0093, 32'h8000_0004} || req_count != rq) begin
            errors++;
            $display("[TB] FAIL hit_inst: got valid=%b inst=%h pc=%h reqs=%0d required 1/00100093/80000004/0",
                     obs_inst_valid, obs_inst, obs_inst_pc, req_count - rq);
        end
    endtask

    task automatic test_redirect_wait();
        int  n = 0;
        bit  saw_inst = 1'b0;
        bit  saw_resp = 1'b0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        wait_fire("rw_req");
        checks++;
        if (obs_req_addr !== 32'h8000_0008) begin
            errors++;
            $display("[TB] FAIL rw_addr: got %h required 80000008", obs_req_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        do begin
            tick(); n++;
            saw_inst |= obs_inst_valid;
            saw_resp |= obs_resp;
        end while (!obs_req_fire && n < 30);
        checks++;
        if ({obs_req_fire, obs_req_addr, saw_inst, saw_resp} !== {1'b1, 32'h8000_0100, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL rw_refetch: got fire=%b addr=%h inst_seen=%b resp_seen=%b required 1/80000100/0/1",
                     obs_req_fire, obs_req_addr, saw_inst, saw_resp);
        end
        wait_inst("rw_inst");
        checks++;
        if ({obs_inst, obs_inst_pc} !== {word_at(32'h8000_0100), 32'h8000_0100}) begin
            errors++;
            $display("[TB] FAIL rw_inst_data: got inst=%h pc=%h required %h/80000100",
                     obs_inst, obs_inst_pc, word_at(32'h8000_0100));
        end
    endtask

    task automatic test_redirect_out();
        int rq;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0000;
        tick();
        redirect_valid = 1'b0;
        wait_inst("ro_setup");
        checks++;
        if (obs_inst_pc !== 32'h8000_0000) begin
            errors++;
            $display("[TB] FAIL ro_setup_pc: got %h required 80000000", obs_inst_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0004;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        rq = req_count;
        tick();
        checks++;
        if (obs_inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ro_drop: inst_valid got %b required 0", obs_inst_valid);
        end
        tick();
        checks++;
        if ({obs_inst_valid, obs_inst, obs_inst_pc} !== {1'b1, 32'h0010_0093, 32'h8000_0004} || req_count != rq) begin
            errors++;
            $display("[TB] FAIL ro_hit: got valid=%b inst=%h pc=%h reqs=%0d required 1/00100093/80000004/0",
                     obs_inst_valid, obs_inst, obs_inst_pc, req_count - rq);
        end
    endtask

    task automatic test_fence();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0000;
        tick();
        redirect_valid = 1'b0;
        tick();
        fence_i = 1'b1;
        tick();
        fence_i = 1'b0;
        checks++;
        if ({obs_inst_valid, obs_inst_pc} !== {1'b1, 32'h8000_0000}) begin
            errors++;
            $display("[TB] FAIL fence_hold: got valid=%b pc=%h required 1/80000000", obs_inst_valid, obs_inst_pc);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tick();
        checks++;
        if ({obs_req_valid, obs_req_addr} !== {1'b1, 32'h8000_0000}) begin
            errors++;
            $display("[TB] FAIL fence_miss: got req=%b addr=%h required 1/80000000", obs_req_valid, obs_req_addr);
        end
        wait_inst("fence_inst");
        checks++;
        if ({obs_inst, obs_inst_pc} !== {32'h0010_0093, 32'h8000_0004}) begin
            errors++;
            $display("[TB] FAIL fence_inst_data: got inst=%h pc=%h required 00100093/80000004", obs_inst, obs_inst_pc);
        end
    endtask

    task automatic test_ready_stall();
        hold_ready = 1'b1;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stray_resp = (i == 2);
            tick();
            stray_resp = 1'b0;
            checks++;
            if ({obs_req_valid, obs_req_addr, obs_req_fire, obs_inst_valid} !== {1'b1, 32'h8000_0008, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL ready_stall_%0d: got req=%b addr=%h fire=%b ivalid=%b required 1/80000008/0/0",
                         i, obs_req_valid, obs_req_addr, obs_req_fire, obs_inst_valid);
            end
        end
        hold_ready = 1'b0;
        wait_inst("ready_stall_inst");
        checks++;
        if ({obs_inst, obs_inst_pc} !== {word_at(32'h8000_0008), 32'h8000_0008}) begin
            errors++;
            $display("[TB] FAIL ready_stall_data: got inst=%h pc=%h required %h/80000008",
                     obs_inst, obs_inst_pc, word_at(32'h8000_0008));
        end
    endtask

    task automatic test_mid_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        wait_fire("mid_reset_req");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL mid_reset_out: got valid=%b inst=%h pc=%h required 0/0/0", inst_valid, inst, inst_pc);
        end
        wait_fire("mid_reset_refetch");
        checks++;
        if (obs_req_addr !== 32'h8000_0000) begin
            errors++;
            $display("[TB] FAIL mid_reset_addr: got %h required 80000000", obs_req_addr);
        end
        wait_inst("mid_reset_inst");
        checks++;
        if ({obs_inst, obs_inst_pc} !== {32'h0000_0013, 32'h8000_0000}) begin
            errors++;
            $display("[TB] FAIL mid_reset_data: got inst=%h pc=%h required 00000013/80000000", obs_inst, obs_inst_pc);
        end
    endtask

    // Reference: instructions leave in program order from model_pc, which
    // advances by 4 per completed handshake and jumps on every redirect.
    task automatic test_random();
        logic [31:0] model_pc = 32'h8000_0000;
        logic [31:0] target;
        bit          redir;
        int          delivered = 0;
        ready_delay = $urandom_range(0, 2);
        resp_lat    = $urandom_range(1, 3);
        for (int i = 0; i < 2000; i++) begin
            inst_ready     = ($urandom_range(0, 9) < 7);
            redir          = ($urandom_range(0, 19) == 0);
            target         = 32'h8000_0000 + $urandom_range(0, 511);
            redirect_valid = redir;
            redirect_pc    = target;
            fence_i        = ($urandom_range(0, 29) == 0);
            tick();
            if (obs_req_valid) begin
                checks++;
                if (obs_req_addr !== {model_pc[31:3], 3'b000} || redir) begin
                    errors++;
                    $display("[TB] FAIL rand_req @%0d: got addr=%h redirect=%b required %h/0",
                             cycle, obs_req_addr, redir, {model_pc[31:3], 3'b000});
                end
            end
            if (obs_inst_valid) begin
                checks++;
                if ({obs_inst_pc, obs_inst} !== {model_pc, word_at(model_pc)}) begin
                    errors++;
                    $display("[TB] FAIL rand_inst @%0d: got pc=%h inst=%h required %h/%h",
                             cycle, obs_inst_pc, obs_inst, model_pc, word_at(model_pc));
                end
            end
            if (redir) begin
                model_pc = target & 32'hFFFF_FFFC;
            end else if (obs_accept) begin
                model_pc = model_pc + 32'd4;
                delivered++;
            end
        end
        redirect_valid = 1'b0;
        fence_i        = 1'b0;
        inst_ready     = 1'b0;
        checks++;
        if (delivered < 40) begin
            errors++;
            $display("[TB] FAIL rand_progress: got %0d instructions required at least 40", delivered);
        end
    endtask

    initial begin
        errors = 0; checks = 0; cycle = 0; req_count = 0;
        test_reset();
        test_first_fetch();
        test_decode_stall();
        test_buffer_hit();
        test_redirect_wait();
        test_redirect_out();
        test_fence();
        test_ready_stall();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22040127_ifu.md
Name: ysyx_22040127_ifu

Overview:
Instruction fetch unit that sits directly upstream of the core's decode/execute datapath. It fetches 64-bit doublewords from instruction memory over a valid/ready request and a valid response channel. It selects the 32-bit instruction by pc[2], keeps a one-line doubleword buffer so the second instruction of a doubleword needs no memory access, and presents instruction plus PC to decode over a valid/ready handshake. Branch/jump redirects and fence.i come from execute.

Parameters:
RESET_PC, 32'h80000000, PC loaded on reset
XLEN_MEM, 64, memory data width (fixed 64; only this value is supported)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  doubleword-aligned address {pc[31:3],3'b000}
mem_resp_valid  in  1  response data valid (one per accepted request)
mem_resp_data  in  64  fetched doubleword
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode consumes instruction
inst  out  32  instruction word
inst_pc  out  32  PC of inst
redirect_valid  in  1  control-flow redirect from execute
redirect_pc  in  32  new PC; bits [1:0] forced to 0 internally
fence_i  in  1  invalidate line buffer

Behaviour:
- Clock clk, reset rst: one clock; reset is synchronous and active-high.
- Reset values: pc=RESET_PC, state=S_FETCH, buf_valid=0, discard=0, inst_valid=0, mem_req_valid=0 in the reset cycle, inst=0, inst_pc=0.
- Line buffer: buf_valid, buf_tag[31:3], buf_data[63:0]. Hit when buf_valid && buf_tag==pc[31:3].
- FSM, 3 states:
  - S_FETCH on hit: latch inst = pc[2] ? buf_data[63:32] : buf_data[31:0] and inst_pc=pc, then go to S_OUT. mem_req_valid stays 0.
  - S_FETCH on miss: drive mem_req_valid=1 with mem_req_addr held stable until accepted. When mem_req_ready is also high, go to S_WAIT.
  - S_WAIT on mem_resp_valid with discard=0: fill the buffer (tag=pc[31:3], data), latch inst/inst_pc as above, go to S_OUT.
  - S_WAIT on mem_resp_valid with discard=1: clear discard, drop the data (no fill), go to S_FETCH.
  - S_OUT: inst_valid=1; inst and inst_pc are stable. On inst_ready, set pc<=pc+4 (wraps mod 2^32) and go to S_FETCH.
- Latency:
  - Hit: inst_valid 1 cycle after entering S_FETCH.
  - Miss: inst_valid 1 cycle after mem_resp_valid.
  - Sequential hit throughput: 1 instruction per 2 cycles.
- Redirect has priority over every other event in the same cycle and sets pc<=redirect_pc&~3.
  - In S_FETCH: mem_req_valid forced to 0 that cycle (combinational gating); stay in S_FETCH.
  - In S_WAIT without a response that cycle: set discard=1; stay in S_WAIT until the response arrives.
  - In S_WAIT with a response in the same cycle: drop the response and go to S_FETCH; discard stays 0.
  - In S_OUT: drop the instruction even if inst_ready=1. The handshake does not complete, pc does not advance by 4, and the state goes to S_FETCH.
- fence_i: clears buf_valid at the end of the cycle and overrides a fill in the same cycle. It does not affect pc or state.
- At most one outstanding memory request. mem_resp_valid outside S_WAIT is ignored.
- Reset mid-operation returns to reset values immediately. The memory side shares rst, so no stale response arrives after reset.

Test Plan:
- Reset, then memory with 1-cycle ready and 2-cycle response; dword @0x80000000 = 0x00100093_00000013:
  - Request addr 0x80000000.
  - inst=0x00000013 with pc 0x80000000.
  - After the handshake, inst=0x00100093 with pc 0x80000004 and no new mem_req_valid (buffer hit).
- Decode stall: hold inst_ready=0 for 5 cycles in S_OUT. inst_valid, inst and inst_pc stay constant, and no memory request is issued.
- Redirect during S_WAIT to 0x80000100:
  - The pending response for 0x80000008 is discarded, with no inst_valid.
  - The next request is 0x80000100.
  - The first instruction delivered has inst_pc=0x80000100.
- Redirect in S_OUT together with inst_ready=1, target 0x80000004 (same dword as buffered):
  - The instruction is dropped.
  - Next, inst_valid with inst_pc=0x80000004 from the buffer, with no memory request.
- fence_i asserted while S_OUT holds pc 0x80000000. After the handshake, pc 0x80000004 misses and issues a request to 0x80000000.
- mem_req_ready held low 4 cycles: mem_req_valid stays high and mem_req_addr stays unchanged. A stray mem_resp_valid pulse in S_FETCH has no effect.
